// File: rtl/exe_hazard_unit.sv
// exe_hazard_unit: execute-stage ALU, compare, branch/jump resolution,
// load-use stall detection and two-slot squash after taken transfers.
//
// Ports:
//   CLK, Reset              clock, async active-high reset
//   id_valid, id_rs1/rs2/rd ID-stage instruction (captured into ID/EX)
//   ex_op, ex_funct3        EX opcode (zero-extended) and funct3
//   ex_alu_op               ALU operation select
//   ex_alu_src1/src2        operand muxes (rd1/pc, rd2/extend)
//   ex_rd1/rd2/extend/pc    forwarded operands, immediate, PC
//   ex_rs1/rs2/rd, ex_valid registered ID/EX slice
//   alu_out, cmp            ALU result / target, three-way compare
//   pc_src, reg_wr          redirect PC, EX writes rd
//   flush, pc_delay         squash ID/EX input, hold PC and IF/ID
//
// Config: define LOAD_USE_STALL_EN to enable load-use stall detection;
// when undefined the stall is tied off and the upstream must pad loads.

module exe_hazard_unit (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [7:0]  ex_op,
    input  logic [2:0]  ex_funct3,
    input  logic [2:0]  ex_alu_op,
    input  logic        ex_alu_src1,
    input  logic        ex_alu_src2,
    input  logic [31:0] ex_rd1,
    input  logic [31:0] ex_rd2,
    input  logic [31:0] ex_extend,
    input  logic [31:0] ex_pc,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic        ex_valid,
    output logic [31:0] alu_out,
    output logic [1:0]  cmp,
    output logic        pc_src,
    output logic        reg_wr,
    output logic        flush,
    output logic        pc_delay
);

    localparam logic [7:0] OP_LOAD   = 8'h03;
    localparam logic [7:0] OP_IMM    = 8'h13;
    localparam logic [7:0] OP_STORE  = 8'h23;
    localparam logic [7:0] OP_REG    = 8'h33;
    localparam logic [7:0] OP_BRANCH = 8'h63;
    localparam logic [7:0] OP_JALR   = 8'h67;
    localparam logic [7:0] OP_JAL    = 8'h6F;

`ifdef LOAD_USE_STALL_EN
    localparam logic STALL_EN = 1'b1;
`else
    localparam logic STALL_EN = 1'b0;
`endif

    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;

    logic [31:0] op_a, op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [31:0] cmp_x, cmp_y;
    logic        is_unsigned;
    logic        c_eq, c_lt;
    logic        br_taken;
    logic        is_branch, is_jal, is_jalr;
    logic        lu_hit;
    logic        stall;

    assign is_branch = (ex_op == OP_BRANCH);
    assign is_jal    = (ex_op == OP_JAL);
    assign is_jalr   = (ex_op == OP_JALR);

    // ALU
    assign op_a  = ex_alu_src1 ? ex_pc : ex_rd1;
    assign op_b  = ex_alu_src2 ? ex_extend : ex_rd2;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = 32'h0;
        case (ex_alu_op)
            3'b000:  alu_res = op_a + op_b;
            3'b001:  alu_res = op_a - op_b;
            3'b010:  alu_res = op_a & op_b;
            3'b011:  alu_res = op_a | op_b;
            3'b100:  alu_res = op_a ^ op_b;
            3'b101:  alu_res = op_a << shamt;
            3'b110:  alu_res = op_a >> shamt;
            3'b111:  alu_res = 32'($signed(op_a) >>> shamt);
            default: alu_res = 32'h0;
        endcase
    end

    // JALR target must be halfword aligned
    assign alu_out = is_jalr ? {alu_res[31:1], 1'b0} : alu_res;

    // Compare: branches use both registers, everything else rd1 vs B
    assign cmp_x = ex_rd1;
    assign cmp_y = is_branch ? ex_rd2 : op_b;

    always_comb begin
        is_unsigned = 1'b0;
        if (is_branch && ex_funct3[2:1] == 2'b11)
            is_unsigned = 1'b1;
        else if ((ex_op == OP_IMM || ex_op == OP_REG) &&
                 ex_funct3 == 3'b011)
            is_unsigned = 1'b1;
    end

    assign c_eq = (cmp_x == cmp_y);
    assign c_lt = is_unsigned ? (cmp_x < cmp_y)
                              : ($signed(cmp_x) < $signed(cmp_y));

    always_comb begin
        cmp = 2'b10;
        if (c_eq)
            cmp = 2'b00;
        else if (c_lt)
            cmp = 2'b01;
    end

    // Branch condition; funct3 010/011 are not valid branches
    always_comb begin
        br_taken = 1'b0;
        case (ex_funct3)
            3'b000:  br_taken = c_eq;
            3'b001:  br_taken = ~c_eq;
            3'b100:  br_taken = c_lt;
            3'b101:  br_taken = ~c_lt;
            3'b110:  br_taken = c_lt;
            3'b111:  br_taken = ~c_lt;
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_src = valid_q &
                    ((is_branch & br_taken) | is_jal | is_jalr);
    assign reg_wr = valid_q & ~is_branch & (ex_op != OP_STORE);
    assign flush  = pc_src;

    // Load in EX whose rd feeds the ID instruction
    assign lu_hit = valid_q & (ex_op == OP_LOAD) & (rd_q != 5'd0) &
                    ((rd_q == id_rs1) | (rd_q == id_rs2));
    assign stall    = lu_hit & STALL_EN;
    assign pc_delay = stall & ~flush;

    // ID/EX slice next state
    assign rs1_d   = id_rs1;
    assign rs2_d   = id_rs2;
    assign rd_d    = id_rd;
    assign valid_d = id_valid & ~stall & ~flush & ~flush_q;
    assign flush_d = flush;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            rd_q    <= 5'd0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
        end
    end

    assign ex_rs1   = rs1_q;
    assign ex_rs2   = rs2_q;
    assign ex_rd    = rd_q;
    assign ex_valid = valid_q;

endmodule

// File: tb/tb_exe_hazard_unit.sv
// Scoreboard bench for exe_hazard_unit: stimulus pushes expected
// responses, a negedge monitor pops and compares.

module tb_exe_hazard_unit;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [7:0]  ex_op;
    logic [2:0]  ex_funct3, ex_alu_op;
    logic        ex_alu_src1, ex_alu_src2;
    logic [31:0] ex_rd1, ex_rd2, ex_extend, ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_valid;
    logic [31:0] alu_out;
    logic [1:0]  cmp;
    logic        pc_src, reg_wr, flush, pc_delay;

    exe_hazard_unit dut (
        .CLK(CLK), .Reset(Reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_op(ex_op), .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op),
        .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_extend(ex_extend),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .alu_out(alu_out), .cmp(cmp),
        .pc_src(pc_src), .reg_wr(reg_wr), .flush(flush),
        .pc_delay(pc_delay)
    );

    always #5 CLK = ~CLK;

`ifdef LOAD_USE_STALL_EN
    localparam logic STALL_ON = 1'b1;
`else
    localparam logic STALL_ON = 1'b0;
`endif

    localparam logic [7:0] M_V   = 8'h01;
    localparam logic [7:0] M_RD  = 8'h02;
    localparam logic [7:0] M_ALU = 8'h04;
    localparam logic [7:0] M_CMP = 8'h08;
    localparam logic [7:0] M_PS  = 8'h10;
    localparam logic [7:0] M_RW  = 8'h20;
    localparam logic [7:0] M_FL  = 8'h40;
    localparam logic [7:0] M_PD  = 8'h80;
    localparam logic [7:0] M_ALL = 8'hFF;

    typedef struct {
        string       name;
        logic [7:0]  m;
        logic        v;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [1:0]  c;
        logic        ps, rw, fl, pd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string n, input logic [7:0] m,
                        input logic v, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [1:0] c,
                        input logic ps, input logic rw,
                        input logic fl, input logic pd);
        exp_t x;
        x.name = n; x.m = m; x.v = v; x.rd = rd; x.alu = alu;
        x.c = c; x.ps = ps; x.rw = rw; x.fl = fl; x.pd = pd;
        sb.push_back(x);
    endtask

    task automatic chk(input string n, input string f,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", n, f, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.m[0]) chk(e.name, "ex_valid", 32'(ex_valid), 32'(e.v));
            if (e.m[1]) chk(e.name, "ex_rd", 32'(ex_rd), 32'(e.rd));
            if (e.m[2]) chk(e.name, "alu_out", alu_out, e.alu);
            if (e.m[3]) chk(e.name, "cmp", 32'(cmp), 32'(e.c));
            if (e.m[4]) chk(e.name, "pc_src", 32'(pc_src), 32'(e.ps));
            if (e.m[5]) chk(e.name, "reg_wr", 32'(reg_wr), 32'(e.rw));
            if (e.m[6]) chk(e.name, "flush", 32'(flush), 32'(e.fl));
            if (e.m[7]) chk(e.name, "pc_delay", 32'(pc_delay), 32'(e.pd));
        end
    end

    task automatic setex(input logic [7:0] op, input logic [2:0] f3,
                         input logic [2:0] aop, input logic s1,
                         input logic s2, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] ext,
                         input logic [31:0] pc);
        ex_op = op; ex_funct3 = f3; ex_alu_op = aop;
        ex_alu_src1 = s1; ex_alu_src2 = s2;
        ex_rd1 = r1; ex_rd2 = r2; ex_extend = ext; ex_pc = pc;
    endtask

    task automatic setid(input logic v, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        setid(1'b1, 5'd1, 5'd2, 5'd7);
        setex(8'h6F, 3'd0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

        step();
        push("reset", M_V | M_RD | M_PS | M_RW | M_FL | M_PD,
             1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        step();
        Reset = 1'b0;
        push("reset_hold", M_V | M_RD | M_PS,
             1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        step();
        setex(8'h13, 3'd0, 3'd0, 1'b0, 1'b1,
              32'd5, 32'h0, 32'hFFFF_FFFD, 32'h0);
        setid(1'b1, 5'd0, 5'd0, 5'd8);
        push("addi_neg", M_ALL, 1'b1, 5'd7, 32'd2, 2'b10,
             1'b0, 1'b1, 1'b0, 1'b0);

        step();
        setex(8'h33, 3'd0, 3'd7, 1'b0, 1'b1,
              32'h8000_0000, 32'h0, 32'd4, 32'h0);
        setid(1'b1, 5'd0, 5'd0, 5'd9);
        push("sra", M_V | M_RD | M_ALU | M_CMP | M_RW, 1'b1, 5'd8,
             32'hF800_0000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);

        step();
        setex(8'h33, 3'd3, 3'd6, 1'b0, 1'b1,
              32'h8000_0000, 32'h0, 32'd4, 32'h0);
        setid(1'b1, 5'd0, 5'd0, 5'd3);
        push("srl_sltu", M_V | M_RD | M_ALU | M_CMP, 1'b1, 5'd9,
             32'h0800_0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);

        step();
        setex(8'h13, 3'd0, 3'd1, 1'b0, 1'b0,
              32'h0, 32'd1, 32'h0, 32'h0);
        setid(1'b1, 5'd0, 5'd0, 5'd5);
        push("sub_wrap", M_RD | M_ALU | M_CMP | M_RW, 1'b1, 5'd3,
             32'hFFFF_FFFF, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);

        step();
        setex(8'h03, 3'd2, 3'd0, 1'b0, 1'b1,
              32'h1000, 32'h0, 32'd4, 32'h0);
        setid(1'b1, 5'd9, 5'd5, 5'd6);
        push("lu_stall", M_V | M_RD | M_RW | M_FL | M_PD, 1'b1, 5'd5,
             32'h0, 2'b00, 1'b0, 1'b1, 1'b0, STALL_ON);

        step();
        setex(8'h13, 3'd0, 3'd0, 1'b0, 1'b0,
              32'h0, 32'h0, 32'h0, 32'h0);
        setid(1'b1, 5'd0, 5'd0, 5'd0);
        push("lu_bubble", M_V | M_RD | M_RW | M_PD, ~STALL_ON, 5'd6,
             32'h0, 2'b00, 1'b0, ~STALL_ON, 1'b0, 1'b0);

        step();
        setex(8'h03, 3'd2, 3'd0, 1'b0, 1'b1,
              32'h1000, 32'h0, 32'd4, 32'h0);
        setid(1'b1, 5'd0, 5'd3, 5'd4);
        push("lu_rd0", M_V | M_RD | M_PD, 1'b1, 5'd0,
             32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        step();
        setex(8'h63, 3'd6, 3'd0, 1'b1, 1'b1,
              32'd1, 32'hFFFF_FFFF, 32'h20, 32'h100);
        setid(1'b1, 5'd0, 5'd0, 5'd10);
        push("bltu_taken", M_ALL, 1'b1, 5'd4, 32'h120, 2'b01,
             1'b1, 1'b0, 1'b1, 1'b0);

        step();
        push("squash1", M_V | M_RD | M_PS | M_FL, 1'b0, 5'd10,
             32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        step();
        push("squash2", M_V | M_PS, 1'b0, 5'd0,
             32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        step();
        setex(8'h63, 3'd4, 3'd0, 1'b1, 1'b1,
              32'd1, 32'hFFFF_FFFF, 32'h20, 32'h100);
        setid(1'b1, 5'd0, 5'd0, 5'd11);
        push("blt_not", M_V | M_RD | M_CMP | M_PS | M_RW | M_FL,
             1'b1, 5'd10, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);

        step();
        setex(8'h67, 3'd0, 3'd0, 1'b0, 1'b1,
              32'h1003, 32'h0, 32'd2, 32'h0);
        setid(1'b1, 5'd11, 5'd0, 5'd12);
        push("jalr", M_V | M_RD | M_ALU | M_PS | M_RW | M_FL | M_PD,
             1'b1, 5'd11, 32'h1004, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);

        step();
        Reset = 1'b1;
        setex(8'h63, 3'd0, 3'd0, 1'b1, 1'b1,
              32'd5, 32'd5, 32'd8, 32'h300);
        push("rst_mid", M_V | M_RD | M_PS | M_RW | M_FL | M_PD,
             1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #6;
        Reset = 1'b0;

        step();
        setex(8'h6F, 3'd0, 3'd0, 1'b1, 1'b1,
              32'h0, 32'h0, 32'h10, 32'h200);
        setid(1'b1, 5'd0, 5'd0, 5'd13);
        push("jal_post_rst", M_V | M_RD | M_ALU | M_PS | M_RW | M_FL | M_PD,
             1'b1, 5'd12, 32'h210, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);

        step();
        setex(8'h13, 3'd0, 3'd0, 1'b0, 1'b0,
              32'h0, 32'h0, 32'h0, 32'h0);
        push("jal_sq1", M_V | M_RD, 1'b0, 5'd13,
             32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        step();
        push("jal_sq2", M_V, 1'b0, 5'd0,
             32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        step();
        push("resume", M_V | M_RD | M_RW, 1'b1, 5'd13,
             32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 5 && sb.size() != 0; i++)
            @(posedge CLK);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
